// File: rtl/druaga_input_pkg.sv
// Shared constants for the Druaga input conditioning block: PS/2 scan codes,
// joystick bit positions, key register slots and the coin FSM state type.
package druaga_input_pkg;

    localparam logic [8:0] SC_UP        = 9'h075;
    localparam logic [8:0] SC_DOWN      = 9'h072;
    localparam logic [8:0] SC_LEFT      = 9'h06B;
    localparam logic [8:0] SC_RIGHT     = 9'h074;
    localparam logic [8:0] SC_SPACE     = 9'h029;
    localparam logic [8:0] SC_CTRL      = 9'h014;
    localparam logic [8:0] SC_F1        = 9'h005;
    localparam logic [8:0] SC_F2        = 9'h006;
    localparam logic [8:0] SC_START1    = 9'h016;
    localparam logic [8:0] SC_START2    = 9'h01E;
    localparam logic [8:0] SC_COIN1     = 9'h02E;
    localparam logic [8:0] SC_COIN2     = 9'h036;
    localparam logic [8:0] SC_P2_UP     = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN   = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT   = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT  = 9'h034;
    localparam logic [8:0] SC_P2_TRIG1  = 9'h01C;
    localparam logic [8:0] SC_P2_TRIG2  = 9'h01B;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_TRIG1  = 4;
    localparam int JB_TRIG2  = 5;
    localparam int JB_START1 = 6;
    localparam int JB_START2 = 7;
    localparam int JB_COIN   = 8;

    localparam int NUM_KEYS = 18;
    localparam logic [4:0] K_UP        = 5'd0;
    localparam logic [4:0] K_DOWN      = 5'd1;
    localparam logic [4:0] K_LEFT      = 5'd2;
    localparam logic [4:0] K_RIGHT     = 5'd3;
    localparam logic [4:0] K_TRIG1     = 5'd4;
    localparam logic [4:0] K_TRIG2     = 5'd5;
    localparam logic [4:0] K_F1        = 5'd6;
    localparam logic [4:0] K_F2        = 5'd7;
    localparam logic [4:0] K_START1    = 5'd8;
    localparam logic [4:0] K_START2    = 5'd9;
    localparam logic [4:0] K_COIN1     = 5'd10;
    localparam logic [4:0] K_COIN2     = 5'd11;
    localparam logic [4:0] K_P2_UP     = 5'd12;
    localparam logic [4:0] K_P2_DOWN   = 5'd13;
    localparam logic [4:0] K_P2_LEFT   = 5'd14;
    localparam logic [4:0] K_P2_RIGHT  = 5'd15;
    localparam logic [4:0] K_P2_TRIG1  = 5'd16;
    localparam logic [4:0] K_P2_TRIG2  = 5'd17;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } coin_state_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_slot_t;

    // Arrow keys are matched on the low byte only, so both the extended and
    // the keypad variants drive the same direction.
    function automatic key_slot_t key_lookup(input logic [8:0] code);
        key_slot_t r;
        r.hit = 1'b1;
        r.idx = K_UP;
        if (code[7:0] == SC_UP[7:0])         r.idx = K_UP;
        else if (code[7:0] == SC_DOWN[7:0])  r.idx = K_DOWN;
        else if (code[7:0] == SC_LEFT[7:0])  r.idx = K_LEFT;
        else if (code[7:0] == SC_RIGHT[7:0]) r.idx = K_RIGHT;
        else begin
            case (code)
                SC_SPACE:    r.idx = K_TRIG1;
                SC_CTRL:     r.idx = K_TRIG2;
                SC_F1:       r.idx = K_F1;
                SC_F2:       r.idx = K_F2;
                SC_START1:   r.idx = K_START1;
                SC_START2:   r.idx = K_START2;
                SC_COIN1:    r.idx = K_COIN1;
                SC_COIN2:    r.idx = K_COIN2;
                SC_P2_UP:    r.idx = K_P2_UP;
                SC_P2_DOWN:  r.idx = K_P2_DOWN;
                SC_P2_LEFT:  r.idx = K_P2_LEFT;
                SC_P2_RIGHT: r.idx = K_P2_RIGHT;
                SC_P2_TRIG1: r.idx = K_P2_TRIG1;
                SC_P2_TRIG2: r.idx = K_P2_TRIG2;
                default:     r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Reorders joystick bits into the core's {trig2, trig1, left, down, right, up}.
    function automatic logic [5:0] joy_to_inp(input logic [5:0] j);
        return {j[JB_TRIG2], j[JB_TRIG1], j[JB_LEFT], j[JB_DOWN], j[JB_RIGHT], j[JB_UP]};
    endfunction

endpackage

// File: rtl/druaga_input_cond_if.sv
// Bundle of raw controller inputs and conditioned core-facing outputs.
interface druaga_input_cond_if;
    logic [10:0] PS2_KEY;
    logic [15:0] JOY1;
    logic [15:0] JOY2;
    logic        CABINET;
    logic        VBLK;
    logic [5:0]  INP0;
    logic [5:0]  INP1;
    logic [2:0]  INP2;

    modport master (
        output PS2_KEY, JOY1, JOY2, CABINET, VBLK,
        input  INP0, INP1, INP2
    );

    modport slave (
        input  PS2_KEY, JOY1, JOY2, CABINET, VBLK,
        output INP0, INP1, INP2
    );
endinterface

// File: rtl/coin_pulse.sv
// Converts a coin request into one pulse lasting COIN_FRAMES VBLK rising edges,
// then locks out until the request is released.
module coin_pulse
    import druaga_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int CNT_W       = 4
) (
    input  logic MCLK,
    input  logic RESET,
    input  logic req,
    input  logic vblk_rise,
    output logic pulse
);
    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(COIN_FRAMES);
                end
            end
            // The request is not looked at here, so a release or re-press
            // can neither shorten nor extend the pulse.
            PULSE: begin
                if (vblk_rise) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pulse_d = (state_d == PULSE);
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/druaga_input_cond.sv
// Druaga input conditioning: PS/2 key decode, joystick merge with cabinet
// mapping, and frame-timed coin pulses, all registered toward the core.
module druaga_input_cond
    import druaga_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int CNT_W       = 4
) (
    input  logic               MCLK,
    input  logic               RESET,
    druaga_input_cond_if.slave bus
);
    logic                tog_q, tog_d;
    logic                vblk_q, vblk_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [5:0]          inp0_q, inp0_d;
    logic [5:0]          inp1_q, inp1_d;
    logic [1:0]          start_q, start_d;
    logic                key_ev, vblk_rise;
    logic                req1, req2, pulse1, pulse2;
    logic [5:0]          p1_raw, p2_raw;
    key_slot_t           slot;
    logic                unused_joy_hi;

    assign unused_joy_hi = ^{bus.JOY1[15:9], bus.JOY2[15:9]};

    always_comb begin
        tog_d     = bus.PS2_KEY[10];
        vblk_d    = bus.VBLK;
        key_ev    = bus.PS2_KEY[10] ^ tog_q;
        vblk_rise = bus.VBLK & ~vblk_q;
        slot      = key_lookup(bus.PS2_KEY[8:0]);

        key_d = key_q;
        if (key_ev && slot.hit) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (slot.idx == 5'(i)) key_d[i] = bus.PS2_KEY[9];
            end
        end

        // Upright cabinets share one set of controls, so P2 also drives P1.
        p2_raw = {key_q[K_P2_TRIG2], key_q[K_P2_TRIG1], key_q[K_P2_LEFT],
                  key_q[K_P2_DOWN], key_q[K_P2_RIGHT], key_q[K_P2_UP]}
               | joy_to_inp(bus.JOY2[5:0]);
        p1_raw = {key_q[K_TRIG2], key_q[K_TRIG1], key_q[K_LEFT],
                  key_q[K_DOWN], key_q[K_RIGHT], key_q[K_UP]}
               | joy_to_inp(bus.JOY1[5:0])
               | (bus.CABINET ? 6'b0 : p2_raw);

        inp0_d  = p1_raw;
        inp1_d  = p2_raw;
        start_d = {key_q[K_F2] | key_q[K_START2] | bus.JOY1[JB_START2] | bus.JOY2[JB_START2],
                   key_q[K_F1] | key_q[K_START1] | bus.JOY1[JB_START1] | bus.JOY2[JB_START1]};
        req1    = key_q[K_F1] | key_q[K_COIN1] | bus.JOY1[JB_COIN];
        req2    = key_q[K_F2] | key_q[K_COIN2] | bus.JOY2[JB_COIN];
    end

    // Edge trackers load the live input even in reset so nothing fires right after it.
    always_ff @(posedge MCLK) begin
        tog_q  <= tog_d;
        vblk_q <= vblk_d;
        if (RESET) begin
            key_q   <= '0;
            inp0_q  <= '0;
            inp1_q  <= '0;
            start_q <= '0;
        end else begin
            key_q   <= key_d;
            inp0_q  <= inp0_d;
            inp1_q  <= inp1_d;
            start_q <= start_d;
        end
    end

    coin_pulse #(.COIN_FRAMES(COIN_FRAMES), .CNT_W(CNT_W)) u_coin1 (
        .MCLK      (MCLK),
        .RESET     (RESET),
        .req       (req1),
        .vblk_rise (vblk_rise),
        .pulse     (pulse1)
    );

    coin_pulse #(.COIN_FRAMES(COIN_FRAMES), .CNT_W(CNT_W)) u_coin2 (
        .MCLK      (MCLK),
        .RESET     (RESET),
        .req       (req2),
        .vblk_rise (vblk_rise),
        .pulse     (pulse2)
    );

    assign bus.INP0 = inp0_q;
    assign bus.INP1 = inp1_q;
    assign bus.INP2 = {pulse1 | pulse2, start_q};
endmodule

// File: tb/tb_druaga_input_cond.sv
// Directed bench for druaga_input_cond: key decode, cabinet merge, coin pulse timing, reset.
module tb_druaga_input_cond;
    logic MCLK;
    logic RESET;
    logic tog;
    int   checks;
    int   errors;
    int   hi_frames;
    int   coin_rises;
    int   r0;
    logic prev_coin;

    druaga_input_cond_if bus();

    druaga_input_cond #(.COIN_FRAMES(4), .CNT_W(4)) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        coin_rises = 0;
        prev_coin  = 1'b0;
    end

    always @(negedge MCLK) begin
        if (bus.INP2[2] === 1'b1 && prev_coin !== 1'b1) coin_rises++;
        prev_coin = bus.INP2[2];
    end

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    task automatic ps2_event(input logic pressed, input logic [8:0] code);
        tog = ~tog;
        bus.PS2_KEY = {tog, pressed, code};
        tick();
        tick();
    endtask

    task automatic do_frame;
        if (bus.INP2[2] === 1'b1) hi_frames++;
        bus.VBLK = 1'b1;
        tick();
        bus.VBLK = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) tick();
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL reset_inp0: got %h want %h", bus.INP0, 6'h00); end
        checks++; if (bus.INP1 !== 6'h00) begin errors++; $display("FAIL reset_inp1: got %h want %h", bus.INP1, 6'h00); end
        checks++; if (bus.INP2 !== 3'h0) begin errors++; $display("FAIL reset_inp2: got %h want %h", bus.INP2, 3'h0); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_ps2_key;
        tog = ~tog;
        bus.PS2_KEY = {tog, 1'b1, 9'h175};
        tick();
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL ps2_latency_edge1: got %h want %h", bus.INP0, 6'h00); end
        tick();
        checks++; if (bus.INP0 !== 6'h01) begin errors++; $display("FAIL ps2_up_press: got %h want %h", bus.INP0, 6'h01); end
        ps2_event(1'b0, 9'h175);
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL ps2_up_release: got %h want %h", bus.INP0, 6'h00); end
        ps2_event(1'b1, 9'h074);
        checks++; if (bus.INP0 !== 6'h02) begin errors++; $display("FAIL ps2_right_plain: got %h want %h", bus.INP0, 6'h02); end
        ps2_event(1'b0, 9'h074);
        ps2_event(1'b1, 9'h029);
        checks++; if (bus.INP0 !== 6'h10) begin errors++; $display("FAIL ps2_space_trig1: got %h want %h", bus.INP0, 6'h10); end
        ps2_event(1'b0, 9'h029);
        ps2_event(1'b1, 9'h12E);
        tick();
        checks++; if (bus.INP2 !== 3'h0) begin errors++; $display("FAIL ps2_ext_coin_ignored: got %h want %h", bus.INP2, 3'h0); end
        ps2_event(1'b0, 9'h12E);
    endtask

    task automatic test_p2_keys;
        bus.CABINET = 1'b0;
        ps2_event(1'b1, 9'h02D);
        checks++; if (bus.INP1 !== 6'h01) begin errors++; $display("FAIL p2key_up_inp1: got %h want %h", bus.INP1, 6'h01); end
        checks++; if (bus.INP0 !== 6'h01) begin errors++; $display("FAIL p2key_up_upright_inp0: got %h want %h", bus.INP0, 6'h01); end
        bus.CABINET = 1'b1;
        tick();
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL p2key_cocktail_inp0: got %h want %h", bus.INP0, 6'h00); end
        checks++; if (bus.INP1 !== 6'h01) begin errors++; $display("FAIL p2key_cocktail_inp1: got %h want %h", bus.INP1, 6'h01); end
        ps2_event(1'b0, 9'h02D);
        bus.CABINET = 1'b0;
        tick();
        checks++; if (bus.INP1 !== 6'h00) begin errors++; $display("FAIL p2key_release: got %h want %h", bus.INP1, 6'h00); end
    endtask

    task automatic test_joy_cabinet;
        bus.CABINET = 1'b0;
        bus.JOY2 = 16'h0010;
        tick();
        checks++; if (bus.INP1 !== 6'h10) begin errors++; $display("FAIL joy_upright_inp1: got %h want %h", bus.INP1, 6'h10); end
        checks++; if (bus.INP0 !== 6'h10) begin errors++; $display("FAIL joy_upright_inp0: got %h want %h", bus.INP0, 6'h10); end
        bus.CABINET = 1'b1;
        tick();
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL joy_cocktail_inp0: got %h want %h", bus.INP0, 6'h00); end
        checks++; if (bus.INP1 !== 6'h10) begin errors++; $display("FAIL joy_cocktail_inp1: got %h want %h", bus.INP1, 6'h10); end
        bus.JOY2 = 16'h0000;
        bus.JOY1 = 16'h0021;
        tick();
        checks++; if (bus.INP0 !== 6'h22) begin errors++; $display("FAIL joy1_right_trig2: got %h want %h", bus.INP0, 6'h22); end
        bus.JOY1 = 16'h00C0;
        tick();
        checks++; if (bus.INP2 !== 3'h3) begin errors++; $display("FAIL joy1_starts: got %h want %h", bus.INP2, 3'h3); end
        bus.JOY1 = 16'h0000;
        bus.CABINET = 1'b0;
        tick();
    endtask

    task automatic test_coin_hold;
        r0 = coin_rises;
        bus.JOY1 = 16'h0100;
        tick();
        checks++; if (bus.INP2 !== 3'h4) begin errors++; $display("FAIL coin_hold_start: got %h want %h", bus.INP2, 3'h4); end
        hi_frames = 0;
        repeat (10) do_frame();
        checks++; if (hi_frames !== 4) begin errors++; $display("FAIL coin_hold_width: got %0d want %0d", hi_frames, 4); end
        checks++; if (bus.INP2[2] !== 1'b0) begin errors++; $display("FAIL coin_hold_lockout: got %b want %b", bus.INP2[2], 1'b0); end
        bus.JOY1 = 16'h0000;
        tick();
        tick();
        checks++; if (coin_rises - r0 !== 1) begin errors++; $display("FAIL coin_hold_count: got %0d want %0d", coin_rises - r0, 1); end
    endtask

    task automatic test_coin_tap;
        r0 = coin_rises;
        hi_frames = 0;
        ps2_event(1'b1, 9'h02E);
        checks++; if (bus.INP2 !== 3'h4) begin errors++; $display("FAIL coin_tap_start: got %h want %h", bus.INP2, 3'h4); end
        repeat (48) tick();
        ps2_event(1'b0, 9'h02E);
        do_frame();
        do_frame();
        ps2_event(1'b1, 9'h02E);
        ps2_event(1'b0, 9'h02E);
        repeat (4) do_frame();
        checks++; if (hi_frames !== 4) begin errors++; $display("FAIL coin_tap_width: got %0d want %0d", hi_frames, 4); end
        checks++; if (bus.INP2[2] !== 1'b0) begin errors++; $display("FAIL coin_tap_end: got %b want %b", bus.INP2[2], 1'b0); end
        checks++; if (coin_rises - r0 !== 1) begin errors++; $display("FAIL coin_tap_count: got %0d want %0d", coin_rises - r0, 1); end
        bus.JOY1 = 16'h0100;
        tick();
        bus.JOY1 = 16'h0000;
        checks++; if (bus.INP2[2] !== 1'b1) begin errors++; $display("FAIL coin_after_release: got %b want %b", bus.INP2[2], 1'b1); end
        repeat (4) do_frame();
        tick();
    endtask

    task automatic test_coin_same_edge;
        hi_frames = 0;
        bus.VBLK = 1'b1;
        bus.JOY2 = 16'h0100;
        tick();
        bus.VBLK = 1'b0;
        checks++; if (bus.INP2 !== 3'h4) begin errors++; $display("FAIL coin_same_edge_start: got %h want %h", bus.INP2, 3'h4); end
        tick();
        tick();
        repeat (5) do_frame();
        checks++; if (hi_frames !== 4) begin errors++; $display("FAIL coin_same_edge_width: got %0d want %0d", hi_frames, 4); end
        bus.JOY2 = 16'h0000;
        tick();
        tick();
    endtask

    task automatic test_coin_both;
        r0 = coin_rises;
        hi_frames = 0;
        bus.JOY2 = 16'h0100;
        tick();
        do_frame();
        do_frame();
        bus.JOY1 = 16'h0100;
        tick();
        do_frame();
        do_frame();
        checks++; if (bus.INP2[2] !== 1'b1) begin errors++; $display("FAIL coin_both_overlap: got %b want %b", bus.INP2[2], 1'b1); end
        do_frame();
        do_frame();
        checks++; if (bus.INP2[2] !== 1'b0) begin errors++; $display("FAIL coin_both_end: got %b want %b", bus.INP2[2], 1'b0); end
        checks++; if (hi_frames !== 6) begin errors++; $display("FAIL coin_both_width: got %0d want %0d", hi_frames, 6); end
        bus.JOY1 = 16'h0000;
        bus.JOY2 = 16'h0000;
        tick();
        tick();
        checks++; if (coin_rises - r0 !== 1) begin errors++; $display("FAIL coin_both_count: got %0d want %0d", coin_rises - r0, 1); end
    endtask

    task automatic test_f1;
        hi_frames = 0;
        ps2_event(1'b1, 9'h005);
        checks++; if (bus.INP2 !== 3'h5) begin errors++; $display("FAIL f1_press: got %h want %h", bus.INP2, 3'h5); end
        do_frame();
        ps2_event(1'b0, 9'h005);
        checks++; if (bus.INP2 !== 3'h4) begin errors++; $display("FAIL f1_release_start: got %h want %h", bus.INP2, 3'h4); end
        repeat (5) do_frame();
        checks++; if (hi_frames !== 4) begin errors++; $display("FAIL f1_coin_width: got %0d want %0d", hi_frames, 4); end
        checks++; if (bus.INP2 !== 3'h0) begin errors++; $display("FAIL f1_end: got %h want %h", bus.INP2, 3'h0); end
    endtask

    task automatic test_reset_mid_pulse;
        ps2_event(1'b1, 9'h175);
        ps2_event(1'b1, 9'h02E);
        checks++; if (bus.INP0 !== 6'h01) begin errors++; $display("FAIL rstmid_pre_inp0: got %h want %h", bus.INP0, 6'h01); end
        checks++; if (bus.INP2 !== 3'h4) begin errors++; $display("FAIL rstmid_pre_inp2: got %h want %h", bus.INP2, 3'h4); end
        do_frame();
        RESET = 1'b1;
        tick();
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL rstmid_inp0: got %h want %h", bus.INP0, 6'h00); end
        checks++; if (bus.INP1 !== 6'h00) begin errors++; $display("FAIL rstmid_inp1: got %h want %h", bus.INP1, 6'h00); end
        checks++; if (bus.INP2 !== 3'h0) begin errors++; $display("FAIL rstmid_inp2: got %h want %h", bus.INP2, 3'h0); end
        RESET = 1'b0;
        repeat (3) tick();
        checks++; if (bus.INP0 !== 6'h00) begin errors++; $display("FAIL rstmid_no_spurious_key: got %h want %h", bus.INP0, 6'h00); end
        checks++; if (bus.INP2 !== 3'h0) begin errors++; $display("FAIL rstmid_no_coin: got %h want %h", bus.INP2, 3'h0); end
        ps2_event(1'b0, 9'h02E);
        ps2_event(1'b0, 9'h175);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        hi_frames   = 0;
        r0          = 0;
        tog         = 1'b0;
        RESET       = 1'b1;
        bus.PS2_KEY = 11'h000;
        bus.JOY1    = 16'h0000;
        bus.JOY2    = 16'h0000;
        bus.CABINET = 1'b0;
        bus.VBLK    = 1'b0;
        test_reset();
        test_ps2_key();
        test_p2_keys();
        test_joy_cabinet();
        test_coin_hold();
        test_coin_tap();
        test_coin_same_edge();
        test_coin_both();
        test_f1();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
